// File: rtl/mod_exp_stream.sv
// rtl/mod_exp_stream.sv - streaming modular exponentiation (base^power mod modulus)
//
// Purpose:
//   Accepts one {base, power, modulus} triple over three valid/ready streams,
//   computes base^power mod modulus with a single shared bit-serial interleaved
//   modular multiplier, and presents the result on a valid/ready output stream.
//   The exponent is scanned right-to-left (multiply, then square, per bit).
//
// Configuration:
//   MOD_EXP_EARLY_EXIT_EN - when defined, zero exponent bits skip the multiply
//   and the operation finishes as soon as the remaining exponent is zero.
//   When undefined, latency is fixed at SIZE*(1+2*EXP_SIZE)+1 cycles.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous, active-high reset
//   input_base_*         base operand stream (SIZE bits)
//   input_power_*        exponent stream (EXP_SIZE bits)
//   input_modulus_*      modulus stream (SIZE bits)
//   output_tdata         result (0 when modulus is 0)
//   output_tuser         error flag: modulus was 0
//   output_tvalid/tready result stream handshake
//   busy                 high whenever the engine is not idle

module mod_exp_stream #(
  parameter int SIZE     = 64,
  parameter int EXP_SIZE = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SIZE-1:0]     input_base_tdata,
  input  logic                input_base_tvalid,
  output logic                input_base_tready,
  input  logic [EXP_SIZE-1:0] input_power_tdata,
  input  logic                input_power_tvalid,
  output logic                input_power_tready,
  input  logic [SIZE-1:0]     input_modulus_tdata,
  input  logic                input_modulus_tvalid,
  output logic                input_modulus_tready,
  output logic [SIZE-1:0]     output_tdata,
  output logic                output_tuser,
  output logic                output_tvalid,
  input  logic                output_tready,
  output logic                busy
);

  localparam int CW = $clog2(SIZE);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    MUL,
    SQR,
    DONE
  } state_t;

  state_t state, state_next;

  logic [SIZE-1:0]     base_r;
  logic [EXP_SIZE-1:0] power_r;
  logic [SIZE-1:0]     mod_r;
  logic [SIZE-1:0]     result_r;
  logic [SIZE+1:0]     acc_r;
  logic [CW-1:0]       cnt_r;
  logic                err_r;
`ifndef MOD_EXP_EARLY_EXIT_EN
  localparam int IW = $clog2(EXP_SIZE + 1);
  logic [IW-1:0]       iter_r;
`endif

  logic                accept;
  logic                phase_end;
  logic [SIZE-1:0]     mult_src;
  logic                mult_bit;
  logic [SIZE+1:0]     addend;
  logic [SIZE+1:0]     mod_ext;
  logic [SIZE+1:0]     t0, t1, t2;
  logic [SIZE-1:0]     prod;
  logic [EXP_SIZE-1:0] power_sh;

  assign accept = (state == IDLE) && input_base_tvalid && input_power_tvalid
                  && input_modulus_tvalid;
  assign phase_end = (cnt_r == '0);
  assign power_sh  = power_r >> 1;

  // Multiplier bits are consumed MSB first by indexing with the down-counter.
  // The operand being scanned is not committed until the phase ends, so no
  // separate shift copy is needed. REDUCE scans the base itself.
  assign mult_src = (state == MUL) ? result_r : base_r;
  assign mult_bit = mult_src[cnt_r];
  assign mod_ext  = {2'b00, mod_r};

  // REDUCE shifts base bits into the remainder (restoring division); the
  // product phases add the multiplicand (always base_r) for each set bit.
  always_comb begin
    addend = '0;
    if (state == REDUCE)
      addend[0] = mult_bit;
    else if (mult_bit)
      addend = {2'b00, base_r};
  end

  // acc < M, so 2*acc + addend < 3M: two conditional subtractions restore
  // acc < M, and SIZE+2 bits hold every intermediate.
  always_comb begin
    t0 = (acc_r << 1) + addend;
    t1 = (t0 >= mod_ext) ? (t0 - mod_ext) : t0;
    t2 = (t1 >= mod_ext) ? (t1 - mod_ext) : t1;
  end
  assign prod = t2[SIZE-1:0];

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept)
          state_next = (input_modulus_tdata == '0) ? DONE : REDUCE;
      end
      REDUCE: begin
        if (phase_end) begin
`ifdef MOD_EXP_EARLY_EXIT_EN
          if (power_r == '0)
            state_next = DONE;
          else if (power_r[0])
            state_next = MUL;
          else
            state_next = SQR;
`else
          state_next = MUL;
`endif
        end
      end
      MUL: begin
        if (phase_end) begin
`ifdef MOD_EXP_EARLY_EXIT_EN
          // Last set bit: the following square would never be used.
          state_next = (power_sh == '0) ? DONE : SQR;
`else
          state_next = SQR;
`endif
        end
      end
      SQR: begin
        if (phase_end) begin
`ifdef MOD_EXP_EARLY_EXIT_EN
          state_next = power_sh[0] ? MUL : SQR;
`else
          state_next = (iter_r == IW'(EXP_SIZE - 1)) ? DONE : MUL;
`endif
        end
      end
      DONE: begin
        if (output_tready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_r   <= '0;
      power_r  <= '0;
      mod_r    <= '0;
      result_r <= '0;
      acc_r    <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
`ifndef MOD_EXP_EARLY_EXIT_EN
      iter_r   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            base_r   <= input_base_tdata;
            power_r  <= input_power_tdata;
            mod_r    <= input_modulus_tdata;
            err_r    <= (input_modulus_tdata == '0);
            result_r <= '0;
            acc_r    <= '0;
            cnt_r    <= CW'(SIZE - 1);
`ifndef MOD_EXP_EARLY_EXIT_EN
            iter_r   <= '0;
`endif
          end
        end
        REDUCE, MUL, SQR: begin
          acc_r <= phase_end ? '0 : t2;
          cnt_r <= phase_end ? CW'(SIZE - 1) : cnt_r - 1'b1;
          if (phase_end) begin
            if (state == REDUCE) begin
              base_r   <= prod;
              result_r <= (mod_r == SIZE'(1)) ? '0 : SIZE'(1);
            end else if (state == MUL) begin
              // The multiply always runs; only a set bit commits it.
              if (power_r[0])
                result_r <= prod;
            end else begin
              base_r  <= prod;
              power_r <= power_sh;
`ifndef MOD_EXP_EARLY_EXIT_EN
              iter_r  <= iter_r + 1'b1;
`endif
            end
          end
        end
        DONE: begin
          if (output_tready)
            err_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign input_base_tready    = (state == IDLE);
  assign input_power_tready   = (state == IDLE);
  assign input_modulus_tready = (state == IDLE);
  assign output_tvalid        = (state == DONE);
  assign output_tdata         = (state == DONE) ? result_r : '0;
  assign output_tuser         = (state == DONE) && err_r;
  assign busy                 = (state != IDLE);

endmodule

// File: tb/tb_mod_exp_stream.sv
// tb/tb_mod_exp_stream.sv - directed and random checks for mod_exp_stream
module tb_mod_exp_stream;

  localparam int SIZE     = 16;
  localparam int EXP_SIZE = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [SIZE-1:0]     input_base_tdata;
  logic                input_base_tvalid;
  logic                input_base_tready;
  logic [EXP_SIZE-1:0] input_power_tdata;
  logic                input_power_tvalid;
  logic                input_power_tready;
  logic [SIZE-1:0]     input_modulus_tdata;
  logic                input_modulus_tvalid;
  logic                input_modulus_tready;
  logic [SIZE-1:0]     output_tdata;
  logic                output_tuser;
  logic                output_tvalid;
  logic                output_tready;
  logic                busy;

  mod_exp_stream #(.SIZE(SIZE), .EXP_SIZE(EXP_SIZE)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .input_base_tdata    (input_base_tdata),
    .input_base_tvalid   (input_base_tvalid),
    .input_base_tready   (input_base_tready),
    .input_power_tdata   (input_power_tdata),
    .input_power_tvalid  (input_power_tvalid),
    .input_power_tready  (input_power_tready),
    .input_modulus_tdata (input_modulus_tdata),
    .input_modulus_tvalid(input_modulus_tvalid),
    .input_modulus_tready(input_modulus_tready),
    .output_tdata        (output_tdata),
    .output_tuser        (output_tuser),
    .output_tvalid       (output_tvalid),
    .output_tready       (output_tready),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string  name;
    longint base;
    longint power;
    longint modulus;
    longint data;
    int     user;
    int     hold;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic longint ref_modexp(input longint b, input longint p, input longint m);
    longint r, bb;
    if (m == 0) return 0;
    r  = 1 % m;
    bb = b % m;
    for (int i = 0; i < EXP_SIZE; i++) begin
      if (((p >> i) & 1) == 1) r = (r * bb) % m;
      bb = (bb * bb) % m;
    end
    return r;
  endfunction

  function automatic int exp_lat(input longint p, input longint m);
`ifdef MOD_EXP_EARLY_EXIT_EN
    int ones, top;
`endif
    if (m == 0) return 1;
`ifdef MOD_EXP_EARLY_EXIT_EN
    ones = 0;
    top  = 0;
    for (int i = 0; i < EXP_SIZE; i++)
      if (((p >> i) & 1) == 1) begin
        ones++;
        top = i;
      end
    if (ones == 0) return SIZE + 1;
    return SIZE * (1 + ones + top) + 1;
`else
    return SIZE * (1 + 2 * EXP_SIZE) + 1;
`endif
  endfunction

  // Called at a negedge; returns at a negedge with the DUT idle again.
  task automatic run_op(input string name, input longint b, input longint p, input longint m,
                        input longint exp_d, input int exp_u, input int hold);
    int waited;
    int lat;
    input_base_tdata     = SIZE'(b);
    input_power_tdata    = EXP_SIZE'(p);
    input_modulus_tdata  = SIZE'(m);
    input_base_tvalid    = 1'b1;
    input_power_tvalid   = 1'b1;
    input_modulus_tvalid = 1'b1;
    waited = 0;
    while (!input_base_tready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk({name, "_accept"}, input_base_tready, 1);
    @(posedge clk);
    #1;
    input_base_tvalid    = 1'b0;
    input_power_tvalid   = 1'b0;
    input_modulus_tvalid = 1'b0;
    input_base_tdata     = SIZE'($urandom);
    input_power_tdata    = EXP_SIZE'($urandom);
    input_modulus_tdata  = SIZE'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!output_tvalid && lat < 3000);
    chk({name, "_latency"}, lat, exp_lat(p, m));
    chk({name, "_data"}, output_tdata, exp_d);
    chk({name, "_user"}, output_tuser, exp_u);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, output_tvalid, 1);
      chk({name, "_hold_data"}, output_tdata, exp_d);
      chk({name, "_hold_in_ready"}, input_base_tready, 0);
    end
    output_tready = 1'b1;
    @(negedge clk);
    output_tready = 1'b0;
    chk({name, "_valid_drop"}, output_tvalid, 0);
    chk({name, "_in_ready_back"}, input_base_tready, 1);
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    int seen;
    longint rb, rp, rm;

    vecs.push_back('{"v_4_13_497",    4,     13,    497,   445, 0, 5});
    vecs.push_back('{"v_reduce",      1000,  1,     7,     6,   0, 0});
    vecs.push_back('{"v_3_200_50",    3,     200,   50,    1,   0, 0});
    vecs.push_back('{"v_mod0",        123,   77,    0,     0,   1, 0});
    vecs.push_back('{"v_mod1_pow0",   5,     0,     1,     0,   0, 0});
    vecs.push_back('{"v_mod11_pow0",  9,     0,     11,    1,   0, 0});
    vecs.push_back('{"v_2_10_1000",   2,     10,    1000,  24,  0, 0});
    vecs.push_back('{"v_base0",       0,     5,     13,    0,   0, 1});
    vecs.push_back('{"v_base_eq_mod", 65535, 1,     65535, 0,   0, 0});
    vecs.push_back('{"v_max_sq",      65535, 2,     65534, 1,   0, 0});

    rst                  = 1'b1;
    output_tready        = 1'b0;
    input_base_tvalid    = 1'b0;
    input_power_tvalid   = 1'b0;
    input_modulus_tvalid = 1'b0;
    input_base_tdata     = '0;
    input_power_tdata    = '0;
    input_modulus_tdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_tvalid", output_tvalid, 0);
    chk("reset_tdata", output_tdata, 0);
    chk("reset_tuser", output_tuser, 0);
    chk("reset_in_ready", {input_base_tready, input_power_tready, input_modulus_tready}, 7);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].base, vecs[i].power, vecs[i].modulus,
             vecs[i].data, vecs[i].user, vecs[i].hold);

    // Staggered valids: nothing is consumed until all three are present.
    input_base_tdata    = 16'd1000;
    input_power_tdata   = 16'd1;
    input_modulus_tdata = 16'd7;
    input_base_tvalid   = 1'b1;
    repeat (3) @(negedge clk);
    chk("stagger_base_only_busy", busy, 0);
    input_power_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stagger_two_busy", busy, 0);
    chk("stagger_two_ready", input_modulus_tready, 1);
    input_modulus_tvalid = 1'b1;
    @(posedge clk);
    #1;
    chk("stagger_accepted", busy, 1);
    input_base_tvalid    = 1'b0;
    input_power_tvalid   = 1'b0;
    input_modulus_tvalid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!output_tvalid && lat < 3000);
    chk("stagger_latency", lat, exp_lat(1, 7));
    chk("stagger_data", output_tdata, 6);
    output_tready = 1'b1;
    @(negedge clk);
    output_tready = 1'b0;
    chk("stagger_done", output_tvalid, 0);

    // Reset in the middle of the first squaring.
    input_base_tdata     = 16'd4;
    input_power_tdata    = 16'd13;
    input_modulus_tdata  = 16'd497;
    input_base_tvalid    = 1'b1;
    input_power_tvalid   = 1'b1;
    input_modulus_tvalid = 1'b1;
    @(posedge clk);
    #1;
    input_base_tvalid    = 1'b0;
    input_power_tvalid   = 1'b0;
    input_modulus_tvalid = 1'b0;
    repeat (2 * SIZE + 5) @(negedge clk);
    chk("rst_mid_busy", busy, 1);
    rst           = 1'b1;
    output_tready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_idle", busy, 0);
    chk("rst_mid_tvalid", output_tvalid, 0);
    chk("rst_mid_tdata", output_tdata, 0);
    chk("rst_mid_in_ready", input_base_tready, 1);
    seen = 0;
    repeat (600) begin
      @(negedge clk);
      if (output_tvalid) seen = 1;
    end
    output_tready = 1'b0;
    chk("rst_mid_no_output", seen, 0);
    run_op("after_rst", 4, 13, 497, 445, 0, 0);

    // Random operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      rb = longint'($urandom_range(0, 65535));
      rp = longint'($urandom_range(0, 65535));
      rm = longint'($urandom_range(1, 65535));
      run_op("rand", rb, rp, rm, ref_modexp(rb, rp, rm), 0, i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_exp_stream.md
MOD_EXP_STREAM -- requirements
Module: mod_exp_stream

Interface
REQ-001 SHALL have parameter SIZE, default 64, operand and modulus width in bits (>=4).
REQ-002 SHALL have parameter EXP_SIZE, default 64, exponent width in bits (>=1).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have ports input_base_tdata  input  SIZE, input_base_tvalid  input  1, input_base_tready  output  1: base stream.
REQ-006 SHALL have ports input_power_tdata  input  EXP_SIZE, input_power_tvalid  input  1, input_power_tready  output  1: exponent stream.
REQ-007 SHALL have ports input_modulus_tdata  input  SIZE, input_modulus_tvalid  input  1, input_modulus_tready  output  1: modulus stream.
REQ-008 SHALL have ports output_tdata  output  SIZE, output_tuser  output  1 (error flag), output_tvalid  output  1, output_tready  input  1: result stream.
REQ-009 SHALL have port busy  output  1: high whenever state is not IDLE.

Function
REQ-010 SHALL compute output_tdata = base^power mod modulus, exact, for any base, power and modulus >= 1.
REQ-011 SHALL use FSM states IDLE, REDUCE, MUL, SQR, DONE, with one shared bit-serial interleaved modular multiplier (SIZE cycles per product, internal accumulator SIZE+2 bits, up to two conditional subtractions per step).
REQ-012 SHALL assert all three input tready together, only in IDLE; transfer happens only in a cycle where all three tvalid and tready are high (cycle T); partial valids are not consumed.
REQ-013 SHALL register base, power, modulus at T; input data changes after T have no effect.
REQ-014 SHALL on modulus = 0 go IDLE->DONE at T+1 with output_tdata = 0, output_tuser = 1; otherwise output_tuser = 0.
REQ-015 SHALL in REDUCE (SIZE cycles, restoring shift-subtract) replace base by base mod modulus, then initialise result = 1 mod modulus.
REQ-016 SHALL process exponent right-to-left: per bit, MUL (result <= result*base mod M) then SQR (base <= base*base mod M), then shift power right one bit.
REQ-017 SHALL without early exit (see Configuration) run exactly EXP_SIZE iterations, always executing MUL and committing it only when the current bit is 1; latency T -> output_tvalid high = SIZE*(1+2*EXP_SIZE)+1 cycles.
REQ-018 SHALL hold output_tdata, output_tuser, output_tvalid stable in DONE until output_tready is high; on that cycle go to IDLE and drop output_tvalid next cycle.
REQ-019 SHALL not accept new input in the cycle the output handshake completes; input tready rises the following cycle.
REQ-020 SHALL give power = 0 -> result 1 for modulus > 1, result 0 for modulus = 1.

Reset
REQ-021 SHALL on rst, in any state including mid-multiplication, enter IDLE next cycle: output_tvalid = 0, output_tuser = 0, output_tdata = 0, busy = 0, all input tready = 1, internal registers cleared.
REQ-022 SHALL give rst priority over any simultaneous input or output handshake; an in-flight operation is discarded, never output.

Configuration
REQ-023 SHALL when macro MOD_EXP_EARLY_EXIT_EN is defined skip MUL for zero exponent bits and go to DONE as soon as remaining power is 0 (including skipping the SQR after the final 1 bit); power = 0 then gives latency SIZE+1.
REQ-024 SHALL when MOD_EXP_EARLY_EXIT_EN is undefined use fixed, data-independent latency per REQ-017 (constant-time mode); results identical in both modes.

Verification
REQ-025 SHALL cover SIZE=16, EXP_SIZE=16: base 4, power 13, modulus 497 -> output_tdata 445, tuser 0, tvalid exactly 529 cycles after T (macro undefined).
REQ-026 SHALL cover base 1000, power 1, modulus 7 -> 6 (base reduction path); base 3, power 200, modulus 50 -> 1.
REQ-027 SHALL cover modulus 0 -> output_tdata 0, tuser 1, tvalid at T+1; modulus 1, power 0 -> 0; modulus 11, power 0 -> 1 (with macro defined: tvalid at T+17).
REQ-028 SHALL cover output_tready held low 5 cycles in DONE -> tdata/tvalid stable, input tready low throughout, single transfer on release.
REQ-029 SHALL cover rst pulsed mid-SQR -> IDLE next cycle, no output transfer, next operation (4^13 mod 497) returns 445.
REQ-030 SHALL cover staggered tvalid (base at T0, power T0+3, modulus T0+6) -> single accept at T0+6, random back-to-back operations matched against a reference model.
